// File: rtl/red_pipe.sv
`default_nettype none
// ============================================================================
// Module   : red_pipe
// Brief    : Pipelined lane-wise A+B add followed by a registered adder-tree
//            reduction, signed or unsigned per transaction, valid/ready flow.
// Revision : 1.0
// ============================================================================
module red_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sgn,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out
);

  localparam int c_NLANES = WIDTH / LANE;
  localparam int c_TREE   = $clog2(c_NLANES);
  localparam int c_TW     = LANE + 1 + c_TREE;
  localparam int c_NNODE  = 2 * c_NLANES - 1;

  // Every node is held at the final-sum width, already extended per its own
  // sgn, so each pairwise add stays exact without per-level re-extension.
  // Nodes are laid out level by level: lanes first, root last.
  logic [c_TW-1:0] r_node [c_NNODE];
  logic [c_TW-1:0] w_next [c_NNODE];
  logic [c_TREE:0] r_vld;
  logic [c_TREE:0] r_sg;
  logic            w_adv;
  logic [c_TW-1:0] w_fin;
  logic [WIDTH-1:0] w_out;

  assign w_adv     = !r_vld[c_TREE] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[c_TREE];

  generate
    for (genvar i = 0; i < c_NLANES; i++) begin : g_lane
      logic [LANE-1:0] w_a;
      logic [LANE-1:0] w_b;
      logic [c_TW-1:0] w_ea;
      logic [c_TW-1:0] w_eb;
      assign w_a  = A[LANE*i +: LANE];
      assign w_b  = B[LANE*i +: LANE];
      assign w_ea = sgn ? {{(c_TW-LANE){w_a[LANE-1]}}, w_a} : {{(c_TW-LANE){1'b0}}, w_a};
      assign w_eb = sgn ? {{(c_TW-LANE){w_b[LANE-1]}}, w_b} : {{(c_TW-LANE){1'b0}}, w_b};
      assign w_next[i] = w_ea + w_eb;
    end

    for (genvar k = 1; k <= c_TREE; k++) begin : g_lvl
      for (genvar j = 0; j < (c_NLANES >> k); j++) begin : g_node
        localparam int c_SRC = 2*c_NLANES - ((2*c_NLANES) >> (k-1)) + 2*j;
        localparam int c_DST = 2*c_NLANES - ((2*c_NLANES) >> k) + j;
        assign w_next[c_DST] = r_node[c_SRC] + r_node[c_SRC+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_sg  <= '0;
      for (int n = 0; n < c_NNODE; n++) begin
        r_node[n] <= '0;
      end
    end else begin
      if (flush) begin
        r_vld <= '0;
      end else if (w_adv) begin
        r_vld <= {r_vld[c_TREE-1:0], in_valid};
      end
      if (w_adv) begin
        r_sg <= {r_sg[c_TREE-1:0], sgn};
        for (int n = 0; n < c_NNODE; n++) begin
          r_node[n] <= w_next[n];
        end
      end
    end
  end

  assign w_fin = r_node[c_NNODE-1];

  always_comb begin
    w_out = {WIDTH{r_sg[c_TREE] & w_fin[c_TW-1]}};
    w_out[c_TW-1:0] = w_fin;
  end

  assign Out = w_out;

endmodule
`default_nettype wire

// File: tb/tb_red_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_red_pipe
// Brief    : Directed vector bench for red_pipe at 16/8 and 32/8 geometries.
// Revision : 1.0
// ============================================================================
module tb_red_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv16, ir16, sg16, fl16, ov16, or16;
  logic [15:0] a16, b16, out16;
  logic        iv32, ir32, sg32, fl32, ov32, or32;
  logic [31:0] a32, b32, out32;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  red_pipe #(.WIDTH(16), .LANE(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .sgn(sg16), .flush(fl16), .out_valid(ov16), .out_ready(or16), .Out(out16)
  );

  red_pipe #(.WIDTH(32), .LANE(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .sgn(sg32), .flush(fl32), .out_valid(ov32), .out_ready(or32), .Out(out32)
  );

  typedef struct {
    bit          w32;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // In-order scoreboard for the 16-bit unit; any unexpected output is flagged.
  always @(negedge clk) begin
    if (mon_en && ov16 && or16) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL extra_output16: got %h expected none", out16);
      end else begin
        check("stream16", {16'h0, out16}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
    bit ok = 1'b0;
    a16 = a; b16 = b; sg16 = s; iv16 = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir16) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL send16_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s);
    bit ok = 1'b0;
    a32 = a; b32 = b; sg32 = s; iv32 = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir32) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL send32_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    iv32 = 1'b0;
  endtask

  // Called right after the accepting edge; checks exact latency and value.
  task automatic expect_result(input bit w32, input logic [31:0] exp, input string nm);
    int lat = w32 ? 3 : 2;
    repeat (lat - 1) @(negedge clk);
    check({nm, "_early_valid"}, {31'h0, w32 ? ov32 : ov16}, 32'h0);
    @(negedge clk);
    check({nm, "_valid"}, {31'h0, w32 ? ov32 : ov16}, 32'h1);
    check({nm, "_out"}, w32 ? out32 : {16'h0, out16}, exp);
  endtask

  task automatic drain16();
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain16_pending", exp_q.size(), 32'h0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [15:0] held;
    int cnt;

    vecs[0] = '{1'b0, 32'h7F80, 32'h0180, 1'b1, 32'hFF80};
    vecs[1] = '{1'b0, 32'h7F80, 32'h0180, 1'b0, 32'h0180};
    vecs[2] = '{1'b0, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFC};
    vecs[3] = '{1'b0, 32'hFFFF, 32'hFFFF, 1'b0, 32'h03FC};
    vecs[4] = '{1'b0, 32'h0102, 32'h0304, 1'b1, 32'h000A};
    vecs[5] = '{1'b0, 32'h8080, 32'h8080, 1'b1, 32'hFE00};
    vecs[6] = '{1'b1, 32'h01020304, 32'h10203040, 1'b0, 32'h000000AA};
    vecs[7] = '{1'b1, 32'h80808080, 32'h00000000, 1'b1, 32'hFFFFFE00};
    vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h000007F8};
    vecs[9] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFF8};

    rst_n = 1'b0;
    iv16 = 0; a16 = '0; b16 = '0; sg16 = 0; fl16 = 0; or16 = 1;
    iv32 = 0; a32 = '0; b32 = '0; sg32 = 0; fl32 = 0; or32 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid16", {31'h0, ov16}, 32'h0);
    check("rst_out16", {16'h0, out16}, 32'h0);
    check("rst_in_ready16", {31'h0, ir16}, 32'h1);
    check("rst_out_valid32", {31'h0, ov32}, 32'h0);
    check("rst_out32", out32, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_out_valid16", {31'h0, ov16}, 32'h0);
    check("idle_in_ready16", {31'h0, ir16}, 32'h1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].w32) send32(vecs[i].a, vecs[i].b, vecs[i].s);
      else             send16(vecs[i].a[15:0], vecs[i].b[15:0], vecs[i].s);
      expect_result(vecs[i].w32, vecs[i].exp, $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Back-to-back alternating signedness on identical operands.
    mon_en = 1'b1;
    exp_q.push_back(16'hFFFC); exp_q.push_back(16'h03FC);
    exp_q.push_back(16'hFFFC); exp_q.push_back(16'h03FC);
    send16(16'hFFFF, 16'hFFFF, 1'b1);
    send16(16'hFFFF, 16'hFFFF, 1'b0);
    send16(16'hFFFF, 16'hFFFF, 1'b1);
    send16(16'hFFFF, 16'hFFFF, 1'b0);
    drain16();
    @(posedge clk); #1;

    // Five-deep stream with a three-cycle output stall.
    exp_q.push_back(16'h000A); exp_q.push_back(16'hFF80); exp_q.push_back(16'h03FC);
    exp_q.push_back(16'h001E); exp_q.push_back(16'h0100);
    fork
      begin
        send16(16'h0102, 16'h0304, 1'b0);
        send16(16'h7F80, 16'h0180, 1'b1);
        send16(16'hFFFF, 16'hFFFF, 1'b0);
        send16(16'h0505, 16'h0A0A, 1'b1);
        send16(16'h8000, 16'h8000, 1'b0);
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        or16 = 1'b0;
        @(negedge clk);
        held = out16;
        check("stall_out_valid", {31'h0, ov16}, 32'h1);
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          check("stall_in_ready", {31'h0, ir16}, 32'h0);
          check("stall_out_stable", {16'h0, out16}, {16'h0, held});
        end
        @(posedge clk); #1;
        or16 = 1'b1;
      end
    join
    drain16();
    @(posedge clk); #1;

    // Flush two in-flight transactions plus one offered in the same cycle.
    send16(16'h1111, 16'h2222, 1'b0);
    or16 = 1'b0;
    send16(16'h3333, 16'h4444, 1'b0);
    a16 = 16'h5555; b16 = 16'h6666; sg16 = 1'b0; iv16 = 1'b1; fl16 = 1'b1;
    @(posedge clk); #1;
    fl16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ov16) cnt++;
    end
    check("flush_no_output", cnt, 32'h0);
    @(posedge clk); #1;
    exp_q.push_back(16'hFF80);
    send16(16'h7F80, 16'h0180, 1'b1);
    @(negedge clk);
    check("post_flush_early_valid", {31'h0, ov16}, 32'h0);
    @(negedge clk);
    check("post_flush_valid", {31'h0, ov16}, 32'h1);
    drain16();
    mon_en = 1'b0;
    @(posedge clk); #1;

    // Reset with two transactions inside the 3-stage unit.
    send32(32'h01010101, 32'h01010101, 1'b0);
    send32(32'h02020202, 32'h02020202, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid32", {31'h0, ov32}, 32'h0);
    check("midrst_in_ready32", {31'h0, ir32}, 32'h1);
    check("midrst_out32", out32, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov32) cnt++;
    end
    check("midrst_no_output", cnt, 32'h0);
    @(posedge clk); #1;
    send32(32'h01020304, 32'h10203040, 1'b0);
    expect_result(1'b1, 32'h000000AA, "post_rst32");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
